// File: rtl/key_lane_marker_pkg.sv
// rtl/key_lane_marker_pkg.sv - shared types and constants for the key lane marker.
package key_lane_marker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [2:0] lane_t;

    localparam lane_t      LANE_NONE   = 3'd0;
    localparam logic [2:0] COLOUR_FAIL = 3'b100;
    localparam logic [2:0] COLOUR_OFF  = 3'b000;

endpackage

// File: rtl/key_lane_marker_if.sv
// rtl/key_lane_marker_if.sv - request handshake and pixel-write bus of the key lane marker.
interface key_lane_marker_if;
    import key_lane_marker_pkg::*;

    logic       go;
    logic [5:0] offset;
    logic       busy;
    logic       done;
    logic       plot;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    lane_t      lane_id;

    modport master (
        output go, offset,
        input  busy, done, plot, x, y, colour, lane_id
    );

    modport slave (
        input  go, offset,
        output busy, done, plot, x, y, colour, lane_id
    );
endinterface

// File: rtl/key_lane_marker_key_sync.sv
// rtl/key_lane_marker_key_sync.sv - key_sync: two-flop synchroniser for the raw key inputs.
module key_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1_d, s1_q, s2_d, s2_q;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Reset to all ones so the encoder sees "no key pressed" until real samples arrive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/key_lane_marker.sv
// rtl/key_lane_marker.sv - latches the pressed key lane and plots a block in that lane.
// Define KEY_LANE_SYNC_EN to route keys_n through the key_sync two-flop synchroniser.
module key_lane_marker
    import key_lane_marker_pkg::*;
#(
    parameter int         NUM_LANES   = 4,
    parameter int         LANE_W      = 40,
    parameter int         BLOCK_H     = 8,
    parameter int         X_ORIGIN    = 80,
    parameter logic [2:0] FAIL_COLOUR = COLOUR_FAIL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] keys_n,
    key_lane_marker_if.slave     bus
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_LATCH = ST_LATCH;
    localparam logic [1:0] S_DRAW  = ST_DRAW;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam int CW = (LANE_W  > 1) ? $clog2(LANE_W)  : 1;
    localparam int RW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(LANE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(BLOCK_H - 1);

    logic [NUM_LANES-1:0] keys_s;

`ifdef KEY_LANE_SYNC_EN
    key_sync #(.W(NUM_LANES)) u_key_sync (
        .clk (clk),
        .rst (rst),
        .d   (keys_n),
        .q   (keys_s)
    );
`else
    assign keys_s = keys_n;
`endif

    lane_t lane_enc;

    // Ascending scan so the highest pressed index overrides lower ones.
    always_comb begin
        lane_enc = LANE_NONE;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!keys_s[i]) lane_enc = lane_t'(NUM_LANES - i);
        end
    end

    logic [1:0]    state_d, state_q;
    lane_t         lane_d, lane_q;
    logic [5:0]    ybase_d, ybase_q;
    logic [CW-1:0] col_d, col_q;
    logic [RW-1:0] row_d, row_q;
    logic [8:0]    x_d, x_q;
    logic [7:0]    y_d, y_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        ybase_d = ybase_q;
        col_d   = col_q;
        row_d   = row_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d = S_LATCH;
                    lane_d  = lane_enc;
                    ybase_d = bus.offset;
                end
            end
            S_LATCH: begin
                if (lane_q == LANE_NONE) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAW;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_DRAW: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) state_d = S_DONE;
                    else                   row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Coordinates are registered one cycle ahead so they line up with the plot strobe.
        if (state_d == S_DRAW) begin
            x_d = 9'(X_ORIGIN + (int'(lane_d) - 1) * LANE_W + int'(col_d));
            y_d = 8'(int'(ybase_d) + int'(row_d));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lane_q  <= LANE_NONE;
            ybase_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            ybase_q <= ybase_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    logic plot_w;
    assign plot_w      = (state_q == S_DRAW);
    assign bus.plot    = plot_w;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.colour  = plot_w ? FAIL_COLOUR : COLOUR_OFF;
    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.lane_id = lane_q;
endmodule

// File: tb/tb_key_lane_marker.sv
// tb/tb_key_lane_marker.sv - randomized and directed checks of key_lane_marker against a queue-based model.
module tb_key_lane_marker;
    import key_lane_marker_pkg::*;

    localparam int N  = 4;
    localparam int LW = 40;
    localparam int BH = 8;
    localparam int XO = 80;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] keys_n = '1;

    key_lane_marker_if bif();

    key_lane_marker dut (
        .clk    (clk),
        .rst    (rst),
        .keys_n (keys_n),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       plot;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] colour;
        logic [2:0] lane;
    } exp_t;

    exp_t         q[$];
    exp_t         cur;
    logic [N-1:0] k1, k2;
    int tests = 0;
    int fails = 0;
    int pcnt, dcnt, xmin, xmax, ymin, ymax;

    function automatic logic [2:0] ref_lane(input logic [N-1:0] k);
        for (int i = N - 1; i >= 0; i--) if (!k[i]) return 3'(N - i);
        return 3'd0;
    endfunction

    // One queue entry per cycle of the operation: latch, every pixel, then the done cycle.
    task automatic push_op(input logic [2:0] lane, input logic [5:0] off);
        exp_t e;
        e = cur;
        e.busy = 1'b1; e.done = 1'b0; e.plot = 1'b0; e.colour = 3'd0; e.lane = lane;
        q.push_back(e);
        if (lane != 3'd0) begin
            for (int r = 0; r < BH; r++) begin
                for (int c = 0; c < LW; c++) begin
                    e.plot = 1'b1; e.colour = 3'b100;
                    e.x = 9'(XO + (int'(lane) - 1) * LW + c);
                    e.y = 8'(int'(off) + r);
                    q.push_back(e);
                end
            end
        end
        e.plot = 1'b0; e.colour = 3'd0; e.done = 1'b1;
        q.push_back(e);
    endtask

    task automatic model_step();
        logic [N-1:0] enc;
        if (rst) begin
            q.delete();
            cur = '0;
            k1 = '1;
            k2 = '1;
            return;
        end
`ifdef KEY_LANE_SYNC_EN
        enc = k2;
`else
        enc = keys_n;
`endif
        k2 = k1;
        k1 = keys_n;
        if (!cur.busy && bif.go) push_op(ref_lane(enc), bif.offset);
        if (q.size() > 0) cur = q.pop_front();
        else begin
            cur.busy = 1'b0; cur.done = 1'b0; cur.plot = 1'b0; cur.colour = 3'd0;
        end
    endtask

    task automatic compare();
        exp_t act;
        act.busy = bif.busy; act.done = bif.done; act.plot = bif.plot;
        act.x = bif.x; act.y = bif.y; act.colour = bif.colour; act.lane = bif.lane_id;
        tests++;
        if (act !== cur) begin
            fails++;
            $display("FAIL cycle_check t=%0t: got busy=%b done=%b plot=%b x=%0d y=%0d colour=%0d lane=%0d, expected busy=%b done=%b plot=%b x=%0d y=%0d colour=%0d lane=%0d",
                     $time, act.busy, act.done, act.plot, act.x, act.y, act.colour, act.lane,
                     cur.busy, cur.done, cur.plot, cur.x, cur.y, cur.colour, cur.lane);
        end
        if (!rst) begin
            if (bif.plot) begin
                pcnt++;
                if (int'(bif.x) < xmin) xmin = int'(bif.x);
                if (int'(bif.x) > xmax) xmax = int'(bif.x);
                if (int'(bif.y) < ymin) ymin = int'(bif.y);
                if (int'(bif.y) > ymax) ymax = int'(bif.y);
            end
            if (bif.done) dcnt++;
        end
    endtask

    initial begin
        cur = '0;
        k1 = '1;
        k2 = '1;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        pcnt = 0; dcnt = 0; xmin = 1000; xmax = -1; ymin = 1000; ymax = -1;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 1000; i++) begin
            if (dcnt > 0) break;
            @(negedge clk);
        end
        if (dcnt == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got 0 done pulses within 1000 cycles, expected 1", name);
        end
    endtask

    task automatic run_op(input logic [N-1:0] k, input logic [5:0] off, input string name);
        keys_n = k;
        bif.offset = off;
        repeat (3) @(negedge clk);
        clr();
        bif.go = 1'b1;
        @(negedge clk);
        bif.go = 1'b0;
        wait_done(name);
        @(negedge clk);
    endtask

    initial begin
        bif.go = 1'b0;
        bif.offset = 6'd0;
        clr();
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(bif.busy), 0);
        chk("reset_xy", int'({bif.x, bif.y}), 0);
        chk("reset_lane", int'(bif.lane_id), 0);

        // Go presented on the very first edge after reset release; no key pressed.
        clr();
        rst = 1'b0;
        bif.go = 1'b1;
        @(negedge clk);
        bif.go = 1'b0;
        wait_done("first_go");
        chk("first_go_done", dcnt, 1);
        chk("first_go_plots", pcnt, 0);
        @(negedge clk);

        run_op(4'b1011, 6'd10, "lane2");
        chk("lane2_id", int'(bif.lane_id), 2);
        chk("lane2_plots", pcnt, 320);
        chk("lane2_xmin", xmin, 120);
        chk("lane2_xmax", xmax, 159);
        chk("lane2_ymin", ymin, 10);
        chk("lane2_ymax", ymax, 17);
        chk("lane2_done", dcnt, 1);

        run_op(4'b0110, 6'd5, "lane1");
        chk("lane1_id", int'(bif.lane_id), 1);
        chk("lane1_xmin", xmin, 80);
        chk("lane1_xmax", xmax, 119);

        run_op(4'b1111, 6'd33, "nokey");
        chk("nokey_id", int'(bif.lane_id), 0);
        chk("nokey_plots", pcnt, 0);
        chk("nokey_done", dcnt, 1);

        // Lane 4 at the bottom offset with go held high across two operations.
        keys_n = 4'b1110;
        bif.offset = 6'd63;
        repeat (3) @(negedge clk);
        clr();
        bif.go = 1'b1;
        wait_done("held_first");
        chk("lane4_id", int'(bif.lane_id), 4);
        chk("lane4_plots", pcnt, 320);
        chk("lane4_xmin", xmin, 200);
        chk("lane4_xmax", xmax, 239);
        chk("lane4_ymin", ymin, 63);
        chk("lane4_ymax", ymax, 70);
        @(negedge clk);
        clr();
        wait_done("held_second");
        chk("held_second_plots", pcnt, 320);
        bif.go = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a draw.
        keys_n = 4'b1101;
        bif.offset = 6'd20;
        repeat (3) @(negedge clk);
        clr();
        bif.go = 1'b1;
        @(negedge clk);
        bif.go = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (pcnt >= 100) break;
            @(negedge clk);
        end
        chk("abort_reached_px100", int'(pcnt >= 100), 1);
        rst = 1'b1;
        #1;
        chk("abort_outputs_zero",
            int'({bif.busy, bif.done, bif.plot, bif.x, bif.y, bif.colour, bif.lane_id}), 0);
        dcnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", dcnt, 0);
        run_op(4'b1101, 6'd20, "after_abort");
        chk("after_abort_plots", pcnt, 320);
        chk("after_abort_xmin", xmin, 160);

`ifdef KEY_LANE_SYNC_EN
        keys_n = 4'b1111;
        repeat (3) @(negedge clk);
        keys_n = 4'b1011;
        @(negedge clk);
        clr();
        bif.go = 1'b1;
        @(negedge clk);
        bif.go = 1'b0;
        wait_done("sync_short");
        chk("sync_short_lane", int'(bif.lane_id), 0);
        @(negedge clk);
        keys_n = 4'b1111;
        repeat (3) @(negedge clk);
        keys_n = 4'b1011;
        repeat (2) @(negedge clk);
        clr();
        bif.go = 1'b1;
        @(negedge clk);
        bif.go = 1'b0;
        wait_done("sync_ok");
        chk("sync_ok_lane", int'(bif.lane_id), 2);
        @(negedge clk);
`endif

        // Random phase: keys and offset change freely, including mid-draw.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) keys_n = N'($urandom);
            bif.offset = 6'($urandom);
            bif.go = ($urandom_range(0, 11) == 0);
            @(negedge clk);
        end
        bif.go = 1'b0;
        repeat (400) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/key_lane_marker.md
KEY_LANE_MARKER -- requirements
Module: key_lane_marker

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4; number of key lanes, range 2..7.
REQ-002 SHALL have parameter LANE_W, default 40; block width in pixels, equal to the lane pitch.
REQ-003 SHALL have parameter BLOCK_H, default 8; block height in pixels.
REQ-004 SHALL have parameter X_ORIGIN, default 80; x of the lane 1 left edge.
REQ-005 SHALL have parameter FAIL_COLOUR, default 3'b100; colour driven while plotting.
REQ-006 SHALL use one clock and an asynchronous, active-high reset: clock input 1, the system clock; reset input 1, the asynchronous active-high reset.
REQ-007 SHALL have the following further ports:
- keys_n, input, NUM_LANES bits: raw active-low keys; index NUM_LANES-1 is lane 1 (leftmost).
- go, input, 1 bit: start request.
- offset, input, 6 bits: block top y.
- busy, output, 1 bit: high while not IDLE.
- done, output, 1 bit: one-cycle completion pulse.
- plot, output, 1 bit: pixel write strobe.
- x, output, 9 bits: pixel x.
- y, output, 8 bits: pixel y.
- colour, output, 3 bits: pixel colour.
- lane_id, output, 3 bits: latched lane, 0 = none.

Function
REQ-008 SHALL priority-encode the sampled keys: the highest pressed index wins; lane = NUM_LANES - index; no key pressed gives 0.
REQ-009 SHALL implement the FSM IDLE -> LATCH -> DRAW -> DONE -> IDLE.
REQ-010 In IDLE with go=1, SHALL enter LATCH and capture the encoded lane and offset into lane_id and the y base.
REQ-011 In LATCH, SHALL enter DONE when lane_id = 0 (no draw); otherwise SHALL enter DRAW with the column and row counters cleared.
REQ-012 In DRAW:
- SHALL assert plot with x = X_ORIGIN + (lane_id-1)*LANE_W + col and y = offset_latched + row.
- colour SHALL equal FAIL_COLOUR.
- col SHALL increment each cycle; at LANE_W-1, col wraps to 0 and row increments.
REQ-013 SHALL leave DRAW after exactly LANE_W*BLOCK_H plot cycles (pixel at col=LANE_W-1, row=BLOCK_H-1) and enter DONE.
REQ-014 In DONE, SHALL assert done for exactly one cycle, then return to IDLE.
REQ-015 Latency: go sampled in IDLE -> first plot 2 cycles later; no-key case -> done 2 cycles after go.
REQ-016 SHALL ignore go whenever busy=1, including the DONE cycle; go held high SHALL start a new operation on the first IDLE cycle.
REQ-017 SHALL ignore key and offset changes after LATCH until the next IDLE.
REQ-018 x and y arithmetic SHALL truncate silently to 9 and 8 bits; wrap-around is the caller's responsibility.
REQ-019 When not in DRAW, plot SHALL be 0, colour 0, and x/y SHALL hold their last value.

Reset
REQ-020 Reset assertion SHALL asynchronously force IDLE, with busy, done, plot, colour, lane_id, x, y and all counters at 0.
REQ-021 Reset mid-DRAW SHALL abort with no done pulse.
REQ-022 After reset, the first go SHALL be accepted on the first clock edge following deassertion.

Configuration
REQ-023 With KEY_LANE_SYNC_EN defined, keys_n SHALL pass through a 2-flop synchroniser (reset value all ones) before encoding, so a key must be stable 2 cycles before go.
REQ-024 Without KEY_LANE_SYNC_EN, keys_n SHALL be encoded directly in the IDLE-go cycle.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the 3-bit lane id typedef, the LANE_NONE=0 constant and the default colour constants.
REQ-026 The synchroniser SHALL be a separate sub-module, key_sync, instantiated only under KEY_LANE_SYNC_EN; encoder, FSM and counters stay in key_lane_marker.

Verification
REQ-027 keys_n=4'b1011, offset=10, go pulse -> lane_id=2, 320 plot cycles covering x 120..159, y 10..17, then one done.
REQ-028 keys_n=4'b0110 (lanes 1 and 4 pressed) -> lane_id=1, x 80..119.
REQ-029 keys_n=4'b1111, go -> lane_id=0, no plot, done 2 cycles after go.
REQ-030 offset=63, lane 4 -> y 63..70, x 200..239; after done, go ignored during busy, held go restarts on IDLE.
REQ-031 Reset asserted at pixel 100 of a draw -> all outputs 0 immediately, no done, next go starts a full draw.
REQ-032 With KEY_LANE_SYNC_EN, a key pressed 1 cycle before go -> lane_id=0; pressed 2 cycles before go -> correct lane.
